// File: rtl/score_bcd_pkg.sv
// score_bcd_pkg: shared types, widths and the output-packing helper for the
// score binary-to-BCD converter.
package score_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BCD_WIDTH   = 10;
  localparam int DIGIT_WIDTH = 4;
  localparam int HUNDS_WIDTH = 2;
  localparam int MAX_SCORE   = 399;
  localparam logic [DIGIT_WIDTH-1:0] BLANK_NIBBLE = 4'hF;

  // Packs the 3-digit accumulator into the display word. When blanking is
  // enabled and the value is below 10, the tens digit carries the blank code.
  function automatic logic [BCD_WIDTH-1:0] score_bcd_pack(
    input logic [3*DIGIT_WIDTH-1:0] acc,
    input logic                     blank_en
  );
    logic [HUNDS_WIDTH-1:0] hunds;
    logic [DIGIT_WIDTH-1:0] tens;
    logic [DIGIT_WIDTH-1:0] units;
    hunds = HUNDS_WIDTH'(acc[3*DIGIT_WIDTH-1:2*DIGIT_WIDTH]);
    tens  = acc[2*DIGIT_WIDTH-1:DIGIT_WIDTH];
    units = acc[DIGIT_WIDTH-1:0];
    if (blank_en && (acc[3*DIGIT_WIDTH-1:DIGIT_WIDTH] == 8'h00)) begin
      tens = BLANK_NIBBLE;
    end else begin
      tens = acc[2*DIGIT_WIDTH-1:DIGIT_WIDTH];
    end
    return {hunds, tens, units};
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit corrector. A digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import score_bcd_pkg::*;
(
  input  logic [DIGIT_WIDTH-1:0] i_digit,
  output logic [DIGIT_WIDTH-1:0] o_digit
);

  // Add-3 correction for digits >= 5, pass-through otherwise.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/score_bin_to_bcd.sv
// score_bin_to_bcd: sequential shift-and-add-3 converter, one input bit per
// clock, turning the saturated binary score into a packed 10-bit BCD word.
// bcd_data only changes on completion, so the display never sees partial values.
// Optional build macro: SCORE_BCD_LEADING_BLANK_EN (blank tens digit below 10).
module score_bin_to_bcd
  import score_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 9,
  parameter int MAX_VALUE = MAX_SCORE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_data,
  output logic                 busy,
  output logic                 done,
  output logic [BCD_WIDTH-1:0] bcd_data,
  output logic                 overflow
);

  localparam int ACC_W = 3 * DIGIT_WIDTH;
  localparam int SH_W  = ACC_W + BIN_WIDTH;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH + 1) : 1;
  localparam logic [BIN_WIDTH-1:0] MAX_BIN  = BIN_WIDTH'(MAX_VALUE);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(BIN_WIDTH - 1);

`ifdef SCORE_BCD_LEADING_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  state_t               r_state;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;
  logic [BCD_WIDTH-1:0] r_bcd;

  logic [DIGIT_WIDTH-1:0] w_tens_adj;
  logic [DIGIT_WIDTH-1:0] w_units_adj;
  logic [ACC_W-1:0]       w_acc_adj;
  logic [SH_W-1:0]        w_shift;

  // Hundreds never exceeds 3 thanks to input saturation, so only tens and
  // units need correcting before each shift.
  bcd_digit_adj u_tens_adj (
    .i_digit (r_acc[2*DIGIT_WIDTH-1:DIGIT_WIDTH]),
    .o_digit (w_tens_adj)
  );

  bcd_digit_adj u_units_adj (
    .i_digit (r_acc[DIGIT_WIDTH-1:0]),
    .o_digit (w_units_adj)
  );

  assign w_acc_adj = {r_acc[ACC_W-1:2*DIGIT_WIDTH], w_tens_adj, w_units_adj};
  assign w_shift   = {w_acc_adj, r_bin} << 1'b1;

  // Conversion FSM: latch operand on start, shift BIN_WIDTH times, publish result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (bin_data > MAX_BIN) begin
              r_bin      <= MAX_BIN;
              r_overflow <= 1'b1;
            end else begin
              r_bin      <= bin_data;
              r_overflow <= 1'b0;
            end
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_busy <= 1'b0;
          end
        end
        SHIFT: begin
          r_acc <= w_shift[SH_W-1:BIN_WIDTH];
          r_bin <= w_shift[BIN_WIDTH-1:0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_bcd   <= score_bcd_pack(w_shift[SH_W-1:BIN_WIDTH], BLANK_EN);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_done <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_data = r_bcd;
  assign overflow = r_overflow;

endmodule
